// File: rtl/scpu_run_ctrl.sv
// scpu_run_ctrl: run/debug sequencer for the single-cycle CPU.
// It gates the core clock enable through CPU reset, free-run, single-step and halt.
// It walks the register file through the debug read port and streams each
// register out over a valid/ready interface.
// It also keeps a saturating retired-cycle counter with an optional runaway timeout.
module scpu_run_ctrl #(
    parameter int          NREGS      = 32,
    parameter int          XLEN       = 32,
    parameter int          CYC_W      = 32,
    parameter int unsigned MAX_CYCLES = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_run,
    input  logic                     cmd_step,
    input  logic                     cmd_stop,
    input  logic                     cmd_dump,
    output logic                     cpu_reset,
    output logic                     cpu_en,
    input  logic                     cpu_halt,
    input  logic                     cpu_dump,
    output logic [$clog2(NREGS)-1:0] dbg_raddr,
    input  logic [XLEN-1:0]          dbg_rdata,
    output logic                     dump_valid,
    input  logic                     dump_ready,
    output logic [$clog2(NREGS)-1:0] dump_idx,
    output logic [XLEN-1:0]          dump_data,
    output logic [CYC_W-1:0]         cycle_count,
    output logic                     halted,
    output logic                     timeout
);

    localparam int                AW         = $clog2(NREGS);
    localparam logic [AW-1:0]     FIRST_IDX  = AW'(1);
    localparam logic [AW-1:0]     LAST_IDX   = AW'(NREGS - 1);
    localparam logic [CYC_W:0]    MAX_EXT    = (CYC_W+1)'(MAX_CYCLES);
    localparam logic              TIMEOUT_EN = (MAX_CYCLES != 0);

    typedef enum logic [2:0] {
        ST_CPURST   = 3'd0,
        ST_IDLE     = 3'd1,
        ST_RUN      = 3'd2,
        ST_STEP     = 3'd3,
        ST_DUMP_RD  = 3'd4,
        ST_DUMP_OUT = 3'd5,
        ST_HALTED   = 3'd6
    } state_t;

    state_t             state_r;
    state_t             ret_r;
    logic               rst_cnt_r;
    logic [AW-1:0]      idx_r;
    logic [XLEN-1:0]    dump_data_r;
    logic [CYC_W-1:0]   cycle_count_r;
    logic               halted_r;
    logic               timeout_r;
    logic               cpu_reset_r;
    logic               cpu_en_r;
    logic               dump_valid_r;

    state_t             state_nxt_s;
    state_t             ret_nxt_s;
    state_t             cont_s;
    logic [AW-1:0]      idx_nxt_s;
    logic               halt_set_s;
    logic               tmo_set_s;
    logic               tmo_hit_s;

    // Timeout fires on the enabled cycle that would make the count reach MAX_CYCLES.
    always_comb begin
        tmo_hit_s = 1'b0;
        if (TIMEOUT_EN && (({1'b0, cycle_count_r} + (CYC_W+1)'(1)) == MAX_EXT)) begin
            tmo_hit_s = 1'b1;
        end else begin
            tmo_hit_s = 1'b0;
        end
    end

    // Next-state logic: command decode, core-signal priority and dump sequencing.
    always_comb begin
        state_nxt_s = state_r;
        ret_nxt_s   = ret_r;
        idx_nxt_s   = idx_r;
        halt_set_s  = 1'b0;
        tmo_set_s   = 1'b0;
        cont_s      = (state_r == ST_RUN) ? ST_RUN : ST_IDLE;
        case (state_r)
            ST_CPURST: begin
                if (rst_cnt_r) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_CPURST;
                end
            end
            ST_IDLE: begin
                if (cmd_dump) begin
                    state_nxt_s = ST_DUMP_RD;
                    ret_nxt_s   = ST_IDLE;
                    idx_nxt_s   = FIRST_IDX;
                end else if (cmd_step) begin
                    state_nxt_s = ST_STEP;
                end else if (cmd_run) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN, ST_STEP: begin
                // Both states are enabled cycles; halt beats timeout beats dump beats stop.
                if (cpu_halt) begin
                    state_nxt_s = ST_DUMP_RD;
                    ret_nxt_s   = ST_HALTED;
                    idx_nxt_s   = FIRST_IDX;
                    halt_set_s  = 1'b1;
                end else if (tmo_hit_s) begin
                    state_nxt_s = ST_DUMP_RD;
                    ret_nxt_s   = ST_HALTED;
                    idx_nxt_s   = FIRST_IDX;
                    halt_set_s  = 1'b1;
                    tmo_set_s   = 1'b1;
                end else if (cpu_dump) begin
                    state_nxt_s = ST_DUMP_RD;
                    ret_nxt_s   = cont_s;
                    idx_nxt_s   = FIRST_IDX;
                end else if ((state_r == ST_RUN) && cmd_stop) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = cont_s;
                end
            end
            ST_DUMP_RD: begin
                state_nxt_s = ST_DUMP_OUT;
            end
            ST_DUMP_OUT: begin
                if (dump_ready) begin
                    if (idx_r == LAST_IDX) begin
                        state_nxt_s = ret_r;
                    end else begin
                        state_nxt_s = ST_DUMP_RD;
                        idx_nxt_s   = idx_r + AW'(1);
                    end
                end else begin
                    state_nxt_s = ST_DUMP_OUT;
                end
            end
            ST_HALTED: begin
                if (cmd_dump) begin
                    state_nxt_s = ST_DUMP_RD;
                    ret_nxt_s   = ST_HALTED;
                    idx_nxt_s   = FIRST_IDX;
                end else if (cmd_run) begin
                    state_nxt_s = ST_CPURST;
                end else begin
                    state_nxt_s = ST_HALTED;
                end
            end
            default: begin
                state_nxt_s = ST_CPURST;
            end
        endcase
    end

    // State, return state, CPU-reset cycle counter and dump index registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_CPURST;
            ret_r     <= ST_IDLE;
            rst_cnt_r <= 1'b0;
            idx_r     <= '0;
        end else begin
            state_r   <= state_nxt_s;
            ret_r     <= ret_nxt_s;
            rst_cnt_r <= (state_r == ST_CPURST) && (state_nxt_s == ST_CPURST);
            idx_r     <= idx_nxt_s;
        end
    end

    // Moore outputs registered from the next state so they line up with state_r.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_reset_r  <= 1'b1;
            cpu_en_r     <= 1'b0;
            dump_valid_r <= 1'b0;
        end else begin
            cpu_reset_r  <= (state_nxt_s == ST_CPURST);
            cpu_en_r     <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_STEP);
            dump_valid_r <= (state_nxt_s == ST_DUMP_OUT);
        end
    end

    // Capture the debug read data; it is held while the beat waits for ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            dump_data_r <= '0;
        end else if (state_r == ST_DUMP_RD) begin
            dump_data_r <= dbg_rdata;
        end
    end

    // Retired-cycle counter (saturating) and sticky halted/timeout flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count_r <= '0;
            halted_r      <= 1'b0;
            timeout_r     <= 1'b0;
        end else if (state_nxt_s == ST_CPURST) begin
            cycle_count_r <= '0;
            halted_r      <= 1'b0;
            timeout_r     <= 1'b0;
        end else begin
            if (cpu_en_r && (cycle_count_r != {CYC_W{1'b1}})) begin
                cycle_count_r <= cycle_count_r + CYC_W'(1);
            end
            if (halt_set_s) begin
                halted_r <= 1'b1;
            end
            if (tmo_set_s) begin
                timeout_r <= 1'b1;
            end
        end
    end

    assign cpu_reset   = cpu_reset_r;
    assign cpu_en      = cpu_en_r;
    assign dump_valid  = dump_valid_r;
    assign dbg_raddr   = idx_r;
    assign dump_idx    = idx_r;
    assign dump_data   = dump_data_r;
    assign cycle_count = cycle_count_r;
    assign halted      = halted_r;
    assign timeout     = timeout_r;

endmodule
